// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// commit_trace_buffer : ring-buffer capture of retired instructions with a
// fill-stop or circular+PC-trigger mode, drained oldest-first over valid/ready.
// Revision 1.0
// ============================================================================
module commit_trace_buffer #(
   parameter  int XLEN  = 32,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic            i_clock,
   input  logic            i_resetn,
   input  logic            i_commitValid,
   input  logic [XLEN-1:0] i_commitPC,
   input  logic [4:0]      i_commitRd,
   input  logic [XLEN-1:0] i_commitData,
   input  logic            i_arm,
   input  logic            i_mode,
   input  logic [XLEN-1:0] i_trigPC,
   input  logic [AW-1:0]   i_postCount,
   output logic [1:0]      o_state,
   output logic [AW:0]     o_count,
   output logic            o_overflow,
   output logic            o_rdValid,
   input  logic            i_rdReady,
   output logic [XLEN-1:0] o_rdPC,
   output logic [4:0]      o_rdRd,
   output logic [XLEN-1:0] o_rdData,
   output logic [31:0]     o_rdCycle
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_POST    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              mode_q, mode_d;
   logic [XLEN-1:0]   trig_pc_q, trig_pc_d;
   logic [AW-1:0]     post_count_q, post_count_d;
   logic [AW-1:0]     remaining_q, remaining_d;
   logic [31:0]       cycle_q, cycle_d;
   logic              wr_en;
   logic              rd_valid;

   logic [XLEN-1:0]   pc_mem   [DEPTH];
   logic [4:0]        rd_mem   [DEPTH];
   logic [XLEN-1:0]   data_mem [DEPTH];
   logic [31:0]       cyc_mem  [DEPTH];

   assign rd_valid = (state_q == ST_DONE) && (count_q != '0);
   assign cycle_d  = cycle_q + 32'd1;

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      overflow_d   = overflow_q;
      mode_d       = mode_q;
      trig_pc_d    = trig_pc_q;
      post_count_d = post_count_q;
      remaining_d  = remaining_q;
      wr_en        = 1'b0;

      if (i_arm) begin
         state_d      = ST_CAPTURE;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         overflow_d   = 1'b0;
         mode_d       = i_mode;
         trig_pc_d    = i_trigPC;
         post_count_d = i_postCount;
      end else begin
         unique case (state_q)
            ST_CAPTURE, ST_POST: begin
               if (i_commitValid) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  // A full ring drops its oldest record to make room.
                  if (count_q == FULL_COUNT) begin
                     rd_ptr_d   = rd_ptr_q + AW'(1);
                     overflow_d = 1'b1;
                  end else begin
                     count_d = count_q + (AW+1)'(1);
                  end

                  if (!mode_q) begin
                     if (count_q == FULL_COUNT - (AW+1)'(1)) begin
                        state_d = ST_DONE;
                     end
                  end else if (state_q == ST_CAPTURE) begin
                     if (i_commitPC == trig_pc_q) begin
                        if (post_count_q == '0) begin
                           state_d = ST_DONE;
                        end else begin
                           state_d     = ST_POST;
                           remaining_d = post_count_q;
                        end
                     end
                  end else begin
                     remaining_d = remaining_q - AW'(1);
                     if (remaining_q == AW'(1)) begin
                        state_d = ST_DONE;
                     end
                  end
               end
            end
            ST_DONE: begin
               if (rd_valid && i_rdReady) begin
                  rd_ptr_d = rd_ptr_q + AW'(1);
                  count_d  = count_q - (AW+1)'(1);
                  if (count_q == (AW+1)'(1)) begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         mode_q       <= 1'b0;
         trig_pc_q    <= '0;
         post_count_q <= '0;
         remaining_q  <= '0;
         cycle_q      <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         mode_q       <= mode_d;
         trig_pc_q    <= trig_pc_d;
         post_count_q <= post_count_d;
         remaining_q  <= remaining_d;
         cycle_q      <= cycle_d;
      end
   end

   // Storage needs no reset: o_count gates every read.
   always_ff @(posedge i_clock) begin
      if (wr_en) begin
         pc_mem[wr_ptr_q]   <= i_commitPC;
         rd_mem[wr_ptr_q]   <= i_commitRd;
         data_mem[wr_ptr_q] <= i_commitData;
         cyc_mem[wr_ptr_q]  <= cycle_q;
      end
   end

   assign o_state    = state_q;
   assign o_count    = count_q;
   assign o_overflow = overflow_q;
   assign o_rdValid  = rd_valid;
   assign o_rdPC     = pc_mem[rd_ptr_q];
   assign o_rdRd     = rd_mem[rd_ptr_q];
   assign o_rdData   = data_mem[rd_ptr_q];
   assign o_rdCycle  = cyc_mem[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// tb_commit_trace_buffer : queue-based reference model plus directed vectors
// for commit_trace_buffer at DEPTH = 4.
// Revision 1.0
// ============================================================================
module tb_commit_trace_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cv = 1'b0;
   logic [31:0] cpc = '0;
   logic [4:0]  crd = '0;
   logic [31:0] cdata = '0;
   logic        arm = 1'b0;
   logic        mode = 1'b0;
   logic [31:0] trig = '0;
   logic [1:0]  post = '0;
   logic        ready = 1'b0;

   logic [1:0]  o_state;
   logic [2:0]  o_count;
   logic        o_overflow;
   logic        o_rdValid;
   logic [31:0] o_rdPC;
   logic [4:0]  o_rdRd;
   logic [31:0] o_rdData;
   logic [31:0] o_rdCycle;

   int checks = 0;
   int errors = 0;

   commit_trace_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
      .i_clock       (clk),
      .i_resetn      (rstn),
      .i_commitValid (cv),
      .i_commitPC    (cpc),
      .i_commitRd    (crd),
      .i_commitData  (cdata),
      .i_arm         (arm),
      .i_mode        (mode),
      .i_trigPC      (trig),
      .i_postCount   (post),
      .o_state       (o_state),
      .o_count       (o_count),
      .o_overflow    (o_overflow),
      .o_rdValid     (o_rdValid),
      .i_rdReady     (ready),
      .o_rdPC        (o_rdPC),
      .o_rdRd        (o_rdRd),
      .o_rdData      (o_rdData),
      .o_rdCycle     (o_rdCycle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: records held in a queue, state as a small integer.
   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] cyc;
   } rec_t;

   rec_t        m_q[$];
   int          m_state = 0;
   bit          m_ovf = 1'b0;
   bit          m_mode = 1'b0;
   logic [31:0] m_trig = '0;
   int          m_post = 0;
   int          m_rem = 0;
   logic [31:0] m_cycle = '0;

   initial begin
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) begin
            m_q.delete();
            m_state = 0;
            m_ovf   = 1'b0;
            m_cycle = '0;
         end else begin
            logic [31:0] stamp;
            stamp   = m_cycle;
            m_cycle = m_cycle + 32'd1;
            if (arm) begin
               m_q.delete();
               m_state = 1;
               m_ovf   = 1'b0;
               m_mode  = mode;
               m_trig  = trig;
               m_post  = int'(post);
            end else if ((m_state == 1 || m_state == 2) && cv) begin
               m_q.push_back('{cpc, crd, cdata, stamp});
               if (m_q.size() > DEPTH) begin
                  void'(m_q.pop_front());
                  m_ovf = 1'b1;
               end
               if (!m_mode) begin
                  if (m_q.size() == DEPTH) m_state = 3;
               end else if (m_state == 1) begin
                  if (cpc == m_trig) begin
                     if (m_post == 0) m_state = 3;
                     else begin
                        m_state = 2;
                        m_rem   = m_post;
                     end
                  end
               end else begin
                  m_rem--;
                  if (m_rem == 0) m_state = 3;
               end
            end else if (m_state == 3 && ready && m_q.size() != 0) begin
               void'(m_q.pop_front());
               if (m_q.size() == 0) m_state = 0;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("state", 64'(o_state), 64'(m_state));
         chk("count", 64'(o_count), 64'(m_q.size()));
         chk("overflow", 64'(o_overflow), 64'(m_ovf));
         chk("rdValid", 64'(o_rdValid), 64'(m_state == 3 && m_q.size() != 0));
         if (m_state == 3 && m_q.size() != 0) begin
            chk("rdPC", 64'(o_rdPC), 64'(m_q[0].pc));
            chk("rdRd", 64'(o_rdRd), 64'(m_q[0].rd));
            chk("rdData", 64'(o_rdData), 64'(m_q[0].data));
            chk("rdCycle", 64'(o_rdCycle), 64'(m_q[0].cyc));
         end
      end
   end

   // Inputs are applied at a falling edge and consumed by the next rising edge.
   task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                        input logic a, input logic r);
      cv    = v;
      cpc   = pc;
      crd   = rd;
      cdata = pc ^ 32'hA5A5_0000;
      arm   = a;
      ready = r;
      @(negedge clk);
      cv    = 1'b0;
      arm   = 1'b0;
      ready = 1'b0;
   endtask

   task automatic commit(input logic [31:0] pc, input logic [4:0] rd);
      drive(1'b1, pc, rd, 1'b0, 1'b0);
   endtask

   task automatic do_arm(input logic md, input logic [31:0] tp, input logic [1:0] pc_n);
      mode = md;
      trig = tp;
      post = pc_n;
      drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
   endtask

   task automatic pop_expect(input string name, input logic [31:0] pc);
      chk(name, 64'(o_rdPC), 64'(pc));
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [31:0] exp_wrap [4];
      exp_wrap = '{32'h14, 32'h18, 32'h200, 32'h300};

      repeat (2) @(negedge clk);
      chk("reset_state", 64'(o_state), 64'd0);
      chk("reset_count", 64'(o_count), 64'd0);
      rstn = 1'b1;
      @(negedge clk);

      // Fill-and-stop
      do_arm(1'b0, 32'h0, 2'd0);
      for (int i = 0; i < 6; i++) begin
         commit(32'h100 + 32'(4 * i), 5'(i + 1));
         if (i == 3) chk("m0_done_after_4", 64'(o_state), 64'd3);
      end
      chk("m0_count", 64'(o_count), 64'd4);
      chk("m0_overflow", 64'(o_overflow), 64'd0);
      pop_expect("m0_pop0", 32'h100);
      pop_expect("m0_pop1", 32'h104);
      pop_expect("m0_pop2", 32'h108);
      pop_expect("m0_pop3", 32'h10C);
      chk("m0_idle", 64'(o_state), 64'd0);

      // Circular with wrap, trigger and one post record
      do_arm(1'b1, 32'h200, 2'd1);
      for (int i = 0; i < 7; i++) commit(32'(4 * i), 5'd3);
      chk("m1_capture", 64'(o_state), 64'd1);
      commit(32'h200, 5'd0);
      chk("m1_post", 64'(o_state), 64'd2);
      commit(32'h300, 5'd7);
      chk("m1_done", 64'(o_state), 64'd3);
      chk("m1_overflow", 64'(o_overflow), 64'd1);
      for (int i = 0; i < 4; i++) pop_expect("m1_pop", exp_wrap[i]);
      chk("m1_idle", 64'(o_state), 64'd0);

      // Trigger with no post window
      do_arm(1'b1, 32'h200, 2'd0);
      commit(32'h10, 5'd1);
      commit(32'h200, 5'd2);
      chk("p0_done", 64'(o_state), 64'd3);
      chk("p0_count", 64'(o_count), 64'd2);
      pop_expect("p0_pop0", 32'h10);
      pop_expect("p0_pop1", 32'h200);

      // Backpressure
      do_arm(1'b1, 32'h200, 2'd0);
      commit(32'h20, 5'd1);
      commit(32'h24, 5'd2);
      commit(32'h200, 5'd3);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
         chk("bp_hold_pc", 64'(o_rdPC), 64'h20);
      end
      chk("bp_hold_count", 64'(o_count), 64'd3);
      pop_expect("bp_pop0", 32'h20);
      pop_expect("bp_pop1", 32'h24);
      pop_expect("bp_pop2", 32'h200);
      chk("bp_valid_low", 64'(o_rdValid), 64'd0);
      chk("bp_idle", 64'(o_state), 64'd0);

      // Arm with concurrent commit, then re-arm during POST
      mode = 1'b0;
      drive(1'b1, 32'h40, 5'd1, 1'b1, 1'b0);
      chk("arm_drop_commit", 64'(o_count), 64'd0);
      do_arm(1'b1, 32'h500, 2'd3);
      for (int i = 0; i < 5; i++) commit(32'h600 + 32'(4 * i), 5'd4);
      commit(32'h500, 5'd5);
      commit(32'h700, 5'd6);
      chk("rearm_pre_state", 64'(o_state), 64'd2);
      chk("rearm_pre_ovf", 64'(o_overflow), 64'd1);
      do_arm(1'b0, 32'h0, 2'd0);
      chk("rearm_count", 64'(o_count), 64'd0);
      chk("rearm_ovf", 64'(o_overflow), 64'd0);
      chk("rearm_state", 64'(o_state), 64'd1);

      // Asynchronous reset during capture
      commit(32'h800, 5'd1);
      commit(32'h804, 5'd2);
      chk("ar_pre_count", 64'(o_count), 64'd2);
      #3 rstn = 1'b0;
      #1;
      chk("ar_state", 64'(o_state), 64'd0);
      chk("ar_count", 64'(o_count), 64'd0);
      chk("ar_overflow", 64'(o_overflow), 64'd0);
      chk("ar_rdValid", 64'(o_rdValid), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      do_arm(1'b0, 32'h0, 2'd0);
      for (int i = 0; i < 4; i++) commit(32'h900 + 32'(4 * i), 5'(i));
      chk("ar_first_cycle", 64'(o_rdCycle), 64'd1);
      chk("ar_first_pc", 64'(o_rdPC), 64'h900);
      for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
      chk("ar_idle", 64'(o_state), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable on-chip trace capture for retired instructions, for use in silicon and FPGA where per-cycle simulation printing is not available.
- Records commit events (PC, rd index, rd data, cycle stamp) into a DEPTH-entry ring buffer.
- Capture modes: fill-and-stop, or circular with a PC-match trigger and a programmable post-trigger window.
- After capture completes, records drain oldest-first over a valid/ready port to a debug host or testbench.

Parameters:
- XLEN, 32, width of PC and data fields.
- DEPTH, 16, buffer entries; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- i_clock, in, 1, clock.
- i_resetn, in, 1, asynchronous active-low reset.
- i_commitValid, in, 1, one instruction retires this cycle.
- i_commitPC, in, XLEN, PC of the retiring instruction.
- i_commitRd, in, 5, destination register index (0 = no writeback).
- i_commitData, in, XLEN, value written to rd.
- i_arm, in, 1, single-cycle pulse: clear buffer, start capture.
- i_mode, in, 1, 0 = fill-stop, 1 = circular+trigger; sampled on i_arm.
- i_trigPC, in, XLEN, trigger PC; sampled on i_arm.
- i_postCount, in, AW, records captured after the trigger record; sampled on i_arm.
- o_state, out, 2, 0 IDLE, 1 CAPTURE, 2 POST, 3 DONE.
- o_count, out, AW+1, valid records held (0..DEPTH).
- o_overflow, out, 1, sticky: at least one record was overwritten.
- o_rdValid, out, 1, a record is presented.
- i_rdReady, in, 1, consumer accepts the presented record.
- o_rdPC, out, XLEN, record PC.
- o_rdRd, out, 5, record rd index.
- o_rdData, out, XLEN, record rd data.
- o_rdCycle, out, 32, cycle stamp of the record.

Behaviour:
- Reset (asynchronous): state IDLE, pointers 0, o_count 0, o_overflow 0, cycle counter 0, o_rdValid 0. o_rd* fields are don't-care while o_rdValid = 0.
- Cycle counter: 32-bit, increments every clock after reset release, wraps to 0. Each record stores the counter value of its capture edge.
- i_arm (any state, highest priority): next state CAPTURE; pointers and o_count cleared; o_overflow cleared; mode, trigPC and postCount latched. A commit in the same cycle is NOT captured.
- Capture: in CAPTURE or POST, i_commitValid = 1 writes a record at the rising edge. Writes happen regardless of rd index (rd = 0 records kept). o_count reflects the write the cycle after the edge.
- Mode 0: transition to DONE on the edge where o_count reaches DEPTH. Trigger ignored. Overflow never set.
- Mode 1:
  - When full, a new write overwrites the oldest entry, advances the read pointer, and sets o_overflow. o_count stays DEPTH.
  - A commit with PC == trigPC in CAPTURE is captured, then: if postCount = 0, go to DONE; else go to POST with remaining = postCount.
  - In POST, each captured commit decrements remaining; going to DONE on the write that reaches 0.
  - Further trigger matches in POST have no extra effect.
- DONE: no capture. o_rdValid = (state == DONE) && (o_count != 0). o_rd* are combinational from the entry at the read pointer (show-ahead). o_rdValid && i_rdReady pops at the edge: read pointer +1 mod DEPTH, o_count -1. The pop that empties the buffer returns state to IDLE.
- IDLE / CAPTURE / POST: o_rdValid = 0; i_rdReady ignored.
- Pointers wrap modulo DEPTH; full vs empty is distinguished by o_count only.
- Reset mid-capture or mid-drain discards all contents immediately.

Test Plan (DEPTH = 4):
- Mode 0: arm, 6 commits PC 0x100..0x114 with rd = 1..6 -> DONE after 4th; drain gives PCs 0x100, 0x104, 0x108, 0x10C; o_overflow = 0; IDLE after 4th pop.
- Mode 1 wrap: arm (trigPC = 0x200, postCount = 1), commits PC 0x00..0x18 step 4, then 0x200, then 0x300 -> DONE; o_overflow = 1; drain yields 0x14, 0x18, 0x200, 0x300.
- Trigger with postCount = 0: commits 0x10, 0x200 -> DONE immediately; o_count = 2; drain 0x10, 0x200.
- Backpressure: in DONE with o_count = 3, hold i_rdReady = 0 for 5 cycles -> o_rdPC stable and o_count = 3; then ready for 3 cycles -> 3 distinct records in order, o_rdValid falls, IDLE.
- Arm with concurrent commit: same-cycle commit PC 0x40 is dropped (o_count = 0); re-arm during POST clears o_count to 0 and o_overflow to 0.
- Async reset in CAPTURE with o_count = 2 -> all outputs return to reset values without a clock edge; o_rdCycle of the next capture is measured from counter 0.
